// File: rtl/stopwatch_lap_core.sv
// MM:SS up/down stopwatch with pause, lap freeze and blinking field adjust,
// driving a 4-digit active-low multiplexed 7-segment display.
module stopwatch_lap_core #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int ADJ_DIV   = 50_000_000,
    parameter int BLINK_DIV = 25_000_000,
    parameter int SCAN_DIV  = 100_000,
    parameter int MAX_MIN   = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_pulse,
    input  logic       lap_pulse,
    input  logic       adj,
    input  logic       sel,
    input  logic       down,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [6:0] min,
    output logic [5:0] sec,
    output logic       running,
    output logic       expired
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [TW-1:0] TICK_TOP  = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ADJ_TOP   = AW'(ADJ_DIV - 1);
    localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SCAN_TOP  = SW'(SCAN_DIV - 1);
    localparam logic [6:0]    MIN_TOP   = 7'(MAX_MIN);

    logic [TW-1:0] tick_cnt;
    logic [AW-1:0] adj_cnt;
    logic [BW-1:0] blink_cnt;
    logic [SW-1:0] scan_cnt;

    logic tick_stb;
    logic adj_stb;
    logic blink_stb;
    logic scan_stb;

    logic       blink_ph;
    logic [1:0] idx;

    logic       lap_hold;
    logic [6:0] snap_min;
    logic [5:0] snap_sec;

    logic [6:0] min_nx;
    logic [5:0] sec_nx;
    logic       run_nx;
    logic       exp_nx;

    logic [6:0] disp_min;
    logic [5:0] disp_sec;
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic [3:0] dig;
    logic       blank;
    logic [3:0] an_nx;

    assign tick_stb  = running && !adj && (tick_cnt == TICK_TOP);
    assign adj_stb   = (adj_cnt == ADJ_TOP);
    assign blink_stb = (blink_cnt == BLINK_TOP);
    assign scan_stb  = (scan_cnt == SCAN_TOP);

    // Tick divider freezes while paused so a resume keeps the sub-second phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (adj) begin
            tick_cnt <= '0;
        end else if (running) begin
            tick_cnt <= tick_stb ? '0 : tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adj_cnt   <= '0;
            blink_cnt <= '0;
            scan_cnt  <= '0;
            blink_ph  <= 1'b0;
            idx       <= 2'd0;
        end else begin
            adj_cnt   <= adj_stb ? '0 : adj_cnt + 1'b1;
            blink_cnt <= blink_stb ? '0 : blink_cnt + 1'b1;
            scan_cnt  <= scan_stb ? '0 : scan_cnt + 1'b1;
            if (blink_stb) blink_ph <= ~blink_ph;
            if (scan_stb) idx <= idx + 2'd1;
        end
    end

    always_comb begin
        min_nx = min;
        sec_nx = sec;
        run_nx = running;
        exp_nx = expired;
        if (pause_pulse && !adj) run_nx = ~running;
        if (tick_stb) begin
            if (!down) begin
                if (sec == 6'd59) begin
                    sec_nx = 6'd0;
                    min_nx = (min == MIN_TOP) ? 7'd0 : min + 7'd1;
                end else begin
                    sec_nx = sec + 6'd1;
                end
            end else if (min != 7'd0 || sec != 6'd0) begin
                if (sec == 6'd0) begin
                    sec_nx = 6'd59;
                    min_nx = min - 7'd1;
                end else begin
                    sec_nx = sec - 6'd1;
                end
                // Landing on 00:00 stops the count and flags expiry.
                if (min == 7'd0 && sec == 6'd1) begin
                    exp_nx = 1'b1;
                    run_nx = 1'b0;
                end
            end
        end
        if (adj && adj_stb) begin
            if (sel) begin
                sec_nx = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
            end else begin
                min_nx = (min == MIN_TOP) ? 7'd0 : min + 7'd1;
            end
            if (min_nx != 7'd0 || sec_nx != 6'd0) exp_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min     <= 7'd0;
            sec     <= 6'd0;
            running <= 1'b1;
            expired <= 1'b0;
        end else begin
            min     <= min_nx;
            sec     <= sec_nx;
            running <= run_nx;
            expired <= exp_nx;
        end
    end

    // Snapshot uses the pre-tick registers, so a same-cycle tick is excluded.
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_hold <= 1'b0;
            snap_min <= 7'd0;
            snap_sec <= 6'd0;
        end else if (adj) begin
            lap_hold <= 1'b0;
        end else if (lap_pulse) begin
            lap_hold <= ~lap_hold;
            if (!lap_hold) begin
                snap_min <= min;
                snap_sec <= sec;
            end
        end
    end

    assign disp_min = lap_hold ? snap_min : min;
    assign disp_sec = lap_hold ? snap_sec : sec;
    assign min_t    = 4'(disp_min / 7'd10);
    assign min_o    = 4'(disp_min % 7'd10);
    assign sec_t    = 4'(disp_sec / 6'd10);
    assign sec_o    = 4'(disp_sec % 6'd10);

    function automatic logic [6:0] font(input logic [3:0] d);
        logic [6:0] f;
        unique case (d)
            4'd0:    f = 7'b1000000;
            4'd1:    f = 7'b1111001;
            4'd2:    f = 7'b0100100;
            4'd3:    f = 7'b0110000;
            4'd4:    f = 7'b0011001;
            4'd5:    f = 7'b0010010;
            4'd6:    f = 7'b0000010;
            4'd7:    f = 7'b1111000;
            4'd8:    f = 7'b0000000;
            4'd9:    f = 7'b0010000;
            default: f = 7'b1111111;
        endcase
        return f;
    endfunction

    always_comb begin
        dig = 4'd0;
        unique case (idx)
            2'd0: dig = sec_o;
            2'd1: dig = sec_t;
            2'd2: dig = min_o;
            2'd3: dig = min_t;
        endcase
    end

    assign blank = adj && !blink_ph && (sel ? !idx[1] : idx[1]);

    always_comb begin
        an_nx = ~(4'b0001 << idx);
        if (blank) an_nx = 4'b1111;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
        end else begin
            an  <= an_nx;
            seg <= font(dig);
        end
    end

endmodule
